// File: rtl/ppu_pkg.sv
// Shared widths, mode encodings and FSM states for the post-processing unit.
package ppu_pkg;
  localparam int ACC_W = 24;  // accumulator lane width
  localparam int OUT_W = 8;   // output lane width (INT4 is sign-extended into it)
  localparam int SH_W  = 5;   // right-shift field, 0..23

  typedef enum logic [1:0] {
    MODE_INT8     = 2'd0,
    MODE_INT4     = 2'd1,
    MODE_INT4_VSQ = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAX  = 2'd1,
    S_CALC = 2'd2
  } state_e;
endpackage

// File: rtl/ppu_quant.sv
// One-lane requantizer: round-half-up, arithmetic right shift, saturate to INT8/INT4.
module ppu_quant
  import ppu_pkg::*;
(
  input  logic signed [ACC_W-1:0] x,
  input  logic [SH_W-1:0]         shift,
  input  logic                    w4,
  output logic signed [OUT_W-1:0] y
);
  localparam logic signed [ACC_W:0] HI8 = 127;
  localparam logic signed [ACC_W:0] LO8 = -128;
  localparam logic signed [ACC_W:0] HI4 = 7;
  localparam logic signed [ACC_W:0] LO4 = -8;

  logic signed [ACC_W:0] rnd, sum, shr, hi, lo;

  // One extra bit of headroom keeps x + rounding term from overflowing.
  always_comb begin
    rnd = '0;
    if (shift != '0) rnd = (ACC_W+1)'(1) << (shift - SH_W'(1));
    sum = {x[ACC_W-1], x} + rnd;
    shr = sum >>> shift;
    hi  = w4 ? HI4 : HI8;
    lo  = w4 ? LO4 : LO8;
    y   = shr[OUT_W-1:0];
    if (shr > hi)      y = hi[OUT_W-1:0];
    else if (shr < lo) y = lo[OUT_W-1:0];
  end
endmodule

// File: rtl/ppu.sv
// Post-processing unit: global max-abs pass then requantize pass (INT8/INT4),
// or single-pass per-row scaling (INT4_VSQ), over 16-row accumulator bursts.
module ppu
  import ppu_pkg::*;
#(
  parameter int TILES_PER_MTRX = 1024,
  parameter int ROWS           = 16,
  parameter int LANES          = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_ppu_start,
  input  logic [ACC_W*LANES-1:0]   i_acc_data,
  input  logic [1:0]               i_mode,
  input  logic                     i_mtrx_done,
  output logic                     o_valid,
  output logic [3:0]               o_row,
  output logic [OUT_W*LANES-1:0]   o_data,
  output logic [SH_W-1:0]          o_scale,
  output logic                     o_busy
);
  localparam int RW = $clog2(ROWS);
  localparam int BW = (TILES_PER_MTRX > 1) ? $clog2(TILES_PER_MTRX) : 1;

  state_e                      state;
  mode_e                       mode_q;
  logic [ACC_W-1:0]            max_q;
  logic [BW-1:0]               bcnt;
  logic [RW-1:0]               rcnt;
  logic                        busy;

  logic [LANES-1:0][ACC_W-1:0] lane;
  logic [LANES-1:0][ACC_W-1:0] lane_abs;
  logic [LANES-1:0][OUT_W-1:0] q;
  logic [ACC_W-1:0]            row_max, mag;
  logic [SH_W-1:0]             blen, hb, shift;
  logic                        w4, last_row;

  // Bit length of an unsigned magnitude; 0 for 0, 24 for 2^23.
  function automatic logic [SH_W-1:0] bitlen(input logic [ACC_W-1:0] m);
    bitlen = '0;
    for (int i = 0; i < ACC_W; i++)
      if (m[i]) bitlen = SH_W'(i + 1);
  endfunction

  assign lane = i_acc_data;

  generate
    for (genvar g = 0; g < LANES; g++) begin : g_lane
      // Two's-complement negate in 24 bits maps -2^23 onto 2^23 as unsigned.
      assign lane_abs[g] = lane[g][ACC_W-1] ? (~lane[g] + ACC_W'(1)) : lane[g];
      ppu_quant u_quant (
        .x     (lane[g]),
        .shift (shift),
        .w4    (w4),
        .y     (q[g])
      );
    end
  endgenerate

  // Max |lane| over the row currently on the bus.
  always_comb begin
    row_max = '0;
    for (int g = 0; g < LANES; g++)
      if (lane_abs[g] > row_max) row_max = lane_abs[g];
  end

  assign w4       = (mode_q != MODE_INT8);
  assign mag      = (mode_q == MODE_INT4_VSQ) ? row_max : max_q;
  assign blen     = bitlen(mag);
  assign hb       = w4 ? SH_W'(3) : SH_W'(7);
  assign shift    = (blen > hb) ? (blen - hb) : '0;
  assign last_row = busy && (rcnt == RW'(ROWS - 1));
  assign o_busy   = busy;

  // Pass sequencing, max accumulation, burst row counter and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_IDLE;
      mode_q  <= MODE_INT8;
      max_q   <= '0;
      bcnt    <= '0;
      rcnt    <= '0;
      busy    <= 1'b0;
      o_valid <= 1'b0;
      o_row   <= '0;
      o_data  <= '0;
      o_scale <= '0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        S_IDLE: if (i_ppu_start) begin
          mode_q <= mode_e'(i_mode);
          bcnt   <= '0;
          if (mode_e'(i_mode) == MODE_INT4_VSQ) state <= S_CALC;
          else begin
            state <= S_MAX;
            max_q <= '0;
          end
        end
        S_MAX: if (busy) begin
          if (row_max > max_q) max_q <= row_max;
          if (last_row) begin
            if (bcnt == BW'(TILES_PER_MTRX - 1)) begin
              bcnt  <= '0;
              state <= S_CALC;
            end else bcnt <= bcnt + BW'(1);
          end
        end
        S_CALC: if (i_mtrx_done) state <= S_IDLE;
        else if (busy) begin
          o_valid <= 1'b1;
          o_row   <= 4'(rcnt);
          o_data  <= q;
          o_scale <= shift;
          if (last_row) bcnt <= bcnt + BW'(1);
        end
        default: state <= S_IDLE;
      endcase

      // A start while a burst is running is dropped.
      if (busy) begin
        rcnt <= last_row ? '0 : rcnt + RW'(1);
        if (last_row) busy <= 1'b0;
      end else if (i_ppu_start) begin
        busy <= 1'b1;
        rcnt <= '0;
      end
      // End of matrix abandons any burst in flight.
      if (state == S_CALC && i_mtrx_done) begin
        busy <= 1'b0;
        rcnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_ppu.sv
// Directed + randomized bench for ppu against an arithmetic reference model.
module tb_ppu;
  import ppu_pkg::*;
  localparam int LANES = 16;
  localparam int ROWS  = 16;
  localparam int TILES = 2;

  logic                   clk = 1'b0, rst_n = 1'b0, start = 1'b0, done = 1'b0;
  logic [1:0]             mode = 2'd0;
  logic [24*LANES-1:0]    acc = '0;
  logic                   valid, busy;
  logic [3:0]             row;
  logic [8*LANES-1:0]     data;
  logic [4:0]             scale;

  ppu #(.TILES_PER_MTRX(TILES), .ROWS(ROWS), .LANES(LANES)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ppu_start(start), .i_acc_data(acc),
    .i_mode(mode), .i_mtrx_done(done), .o_valid(valid), .o_row(row),
    .o_data(data), .o_scale(scale), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int nchk = 0, nfail = 0;
  int rows [ROWS][LANES];
  logic [127:0] cap_data [ROWS];
  logic [4:0]   cap_scale [ROWS];

  // Reference model state: matrix in progress, latched mode, pass, global max.
  bit     m_idle = 1'b1, m_calc = 1'b0;
  int     m_mode = 0, m_bursts = 0;
  longint gmax = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    assert (act === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  function automatic longint iabs(input int x);
    return (x < 0) ? -longint'(x) : longint'(x);
  endfunction

  // Smallest shift that brings the magnitude under 2^(W-1).
  function automatic int exp_shift(input longint m, input int w);
    int s = 0;
    while ((m >> s) >= (longint'(1) << (w - 1))) s++;
    return s;
  endfunction

  // Round half up, floor divide by 2^s, clamp to the W-bit signed range.
  function automatic int qz(input int x, input int s, input int w);
    longint v, d, r, hi, lo;
    v  = longint'(x) + ((s > 0) ? (longint'(1) << (s - 1)) : 0);
    d  = longint'(1) << s;
    r  = (v >= 0) ? (v / d) : -((-v + d - 1) / d);
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return int'(r);
  endfunction

  task automatic fill_zero();
    for (int r = 0; r < ROWS; r++) for (int g = 0; g < LANES; g++) rows[r][g] = 0;
  endtask

  task automatic fill_rand();
    int k, v;
    for (int r = 0; r < ROWS; r++) for (int g = 0; g < LANES; g++) begin
      k = $urandom_range(0, 23);
      v = (k == 0) ? 0 : int'($urandom_range(0, (1 << k) - 1));
      if ($urandom_range(0, 1) == 1) v = -v;
      if ($urandom_range(0, 63) == 0) v = -8388608;
      rows[r][g] = v;
    end
  endtask

  task automatic fill_bound(input int lim);
    for (int r = 0; r < ROWS; r++) for (int g = 0; g < LANES; g++)
      rows[r][g] = int'($urandom_range(0, 2 * lim)) - lim;
  endtask

  // One burst of ROWS rows; noise adds a stray start (and a stray done in the max pass).
  task automatic run_burst(input int md, input bit noise);
    int w, s, rr;
    longint m;
    logic [127:0] ev;
    bit calc;
    if (m_idle) begin
      m_idle = 1'b0; m_mode = md; m_calc = (md == int'(MODE_INT4_VSQ));
      gmax = 0; m_bursts = 0;
    end
    calc = m_calc;
    w = (m_mode == int'(MODE_INT8)) ? 8 : 4;
    @(negedge clk); start = 1'b1; mode = 2'(md);
    for (int r = 0; r <= ROWS; r++) begin
      @(negedge clk);
      start = noise && (r == 5);
      done  = noise && !calc && (r == 8);
      mode  = (noise && r == 5) ? ~2'(md) : 2'(md);
      if (r > 0) begin
        rr = r - 1;
        if (calc) begin
          m = 0;
          if (m_mode == int'(MODE_INT4_VSQ)) begin
            for (int g = 0; g < LANES; g++) if (iabs(rows[rr][g]) > m) m = iabs(rows[rr][g]);
          end else m = gmax;
          s = exp_shift(m, w);
          for (int g = 0; g < LANES; g++) ev[g*8 +: 8] = 8'(qz(rows[rr][g], s, w));
          chk("valid_calc", 128'(valid), 128'(1));
          chk("row_idx", 128'(row), 128'(rr));
          chk("scale", 128'(scale), 128'(s));
          chk("data", 128'(data), ev);
          cap_data[rr] = data; cap_scale[rr] = scale;
        end else chk("valid_max", 128'(valid), 128'(0));
      end else chk("valid_pre", 128'(valid), 128'(0));
      if (r < ROWS) begin
        chk("busy_burst", 128'(busy), 128'(1));
        for (int g = 0; g < LANES; g++) acc[g*24 +: 24] = 24'(rows[r][g]);
      end
    end
    @(negedge clk);
    chk("valid_post", 128'(valid), 128'(0));
    chk("busy_post", 128'(busy), 128'(0));
    if (!calc) begin
      for (int r = 0; r < ROWS; r++) for (int g = 0; g < LANES; g++)
        if (iabs(rows[r][g]) > gmax) gmax = iabs(rows[r][g]);
      m_bursts++;
      if (m_bursts == TILES) m_calc = 1'b1;
    end
  endtask

  task automatic end_mtrx();
    @(negedge clk); done = 1'b1;
    @(negedge clk); done = 1'b0;
    chk("busy_idle", 128'(busy), 128'(0));
    chk("valid_idle", 128'(valid), 128'(0));
    m_idle = 1'b1; m_calc = 1'b0;
  endtask

  initial begin
    // Reset values
    @(negedge clk);
    chk("rst_valid", 128'(valid), 128'(0));
    chk("rst_row", 128'(row), 128'(0));
    chk("rst_data", 128'(data), 128'(0));
    chk("rst_scale", 128'(scale), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // VSQ directed rows, including the -2^23 extreme
    fill_zero();
    rows[0][0] = 100; rows[0][1] = -100; rows[0][2] = 7;
    rows[1][0] = -8388608;
    run_burst(int'(MODE_INT4_VSQ), 1'b0);
    chk("vsq_l0", 128'(cap_data[0][7:0]), 128'(8'h06));
    chk("vsq_l1", 128'(cap_data[0][15:8]), 128'(8'hFA));
    chk("vsq_l2", 128'(cap_data[0][23:16]), 128'(8'h00));
    chk("vsq_scale", 128'(cap_scale[0]), 128'(4));
    chk("ext_l0", 128'(cap_data[1][7:0]), 128'(8'hFC));
    chk("ext_scale", 128'(cap_scale[1]), 128'(21));

    // VSQ random bursts with a stray start mid-burst
    fill_rand(); run_burst(int'(MODE_INT4_VSQ), 1'b1);
    fill_rand(); run_burst(int'(MODE_INT8), 1'b1);   // mode ignored mid-matrix
    end_mtrx();

    // INT8 two-pass, max 1000 -> shift 3
    fill_bound(999); rows[3][4] = 1000; run_burst(int'(MODE_INT8), 1'b0);
    fill_bound(999); rows[9][1] = -1000; run_burst(int'(MODE_INT8), 1'b1);
    fill_rand(); rows[0][0] = 1000; rows[0][1] = -1000;
    run_burst(int'(MODE_INT8), 1'b0);
    chk("i8_pos", 128'(cap_data[0][7:0]), 128'(8'h7D));
    chk("i8_neg", 128'(cap_data[0][15:8]), 128'(8'h83));
    chk("i8_scale", 128'(cap_scale[0]), 128'(3));
    fill_rand(); run_burst(int'(MODE_INT4_VSQ), 1'b0);
    end_mtrx();

    // INT8 saturation at shift 0
    fill_bound(127); rows[0][0] = 127; run_burst(int'(MODE_INT8), 1'b0);
    fill_bound(127); run_burst(int'(MODE_INT8), 1'b0);
    fill_bound(2000); rows[0][0] = 200; rows[0][1] = -300;
    run_burst(int'(MODE_INT8), 1'b0);
    chk("sat_pos", 128'(cap_data[0][7:0]), 128'(8'h7F));
    chk("sat_neg", 128'(cap_data[0][15:8]), 128'(8'h80));
    chk("sat_scale", 128'(cap_scale[0]), 128'(0));
    end_mtrx();

    // INT4 random two-pass
    fill_rand(); run_burst(int'(MODE_INT4), 1'b0);
    fill_rand(); run_burst(int'(MODE_INT4), 1'b0);
    fill_rand(); run_burst(int'(MODE_INT4), 1'b0);
    fill_rand(); run_burst(int'(MODE_INT4), 1'b1);
    end_mtrx();

    // Reset in the middle of a VSQ burst
    fill_rand();
    @(negedge clk); start = 1'b1; mode = 2'(MODE_INT4_VSQ);
    for (int r = 0; r < 8; r++) begin
      @(negedge clk); start = 1'b0;
      for (int g = 0; g < LANES; g++) acc[g*24 +: 24] = 24'(rows[r][g]);
    end
    @(negedge clk);
    chk("mid_row", 128'(row), 128'(7));
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", 128'(valid), 128'(0));
    chk("arst_busy", 128'(busy), 128'(0));
    chk("arst_data", 128'(data), 128'(0));
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", 128'({valid, busy}), 128'(0));
    end
    m_idle = 1'b1; m_calc = 1'b0;

    // Recovery: fresh VSQ matrix
    fill_rand(); run_burst(int'(MODE_INT4_VSQ), 1'b0);
    end_mtrx();

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
